// File: rtl/accum_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// accum_sched_pkg : shared types, defaults and the round-robin pick helper
// Revision: 1.0
// ----------------------------------------------------------------------------
package accum_sched_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

   // The pick helper works on a fixed-size vector so any N up to this fits.
   localparam int RR_MAX_REQ  = 32;
   localparam int RR_ID_W     = $clog2(RR_MAX_REQ);

   typedef struct packed {
      logic [DEF_ID_W-1:0]  id;
      logic [DEF_WIDTH-1:0] data;
   } rsp_t;

   typedef struct packed {
      logic               found;
      logic [RR_ID_W-1:0] idx;
   } pick_t;

   function automatic pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                     input logic [RR_ID_W-1:0]    ptr,
                                     input int                    n);
      pick_t            r;
      logic [RR_ID_W:0] j;
      r = '0;
      for (int i = 0; i < RR_MAX_REQ; i++) begin
         if (i < n) begin
            j = {1'b0, ptr} + (RR_ID_W+1)'(i);
            if (j >= (RR_ID_W+1)'(n)) begin
               j = j - (RR_ID_W+1)'(n);
            end
            if (!r.found && valid[j[RR_ID_W-1:0]]) begin
               r.found = 1'b1;
               r.idx   = j[RR_ID_W-1:0];
            end
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/accum_sched_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// accum_sched_rr_arbiter : combinational round-robin arbiter, one-hot grant
// Revision: 1.0
// ----------------------------------------------------------------------------
module accum_sched_rr_arbiter
   import accum_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          enable_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o
);

   pick_t w_pick;

   always_comb begin
      w_pick  = rr_pick(RR_MAX_REQ'(valid_i), RR_ID_W'(ptr_i), N);
      idx_o   = IW'(w_pick.idx);
      grant_o = '0;
      if (enable_i && w_pick.found) begin
         grant_o[idx_o] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/accum_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// accum_sched : round-robin time-shared accumulator (acc + operand + 1)
// Revision: 1.0
// ----------------------------------------------------------------------------
module accum_sched
   import accum_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_data,
   input  logic                     rsp_ready
);

   logic [WIDTH-1:0] w_req_data [NUM_REQ];
   logic [WIDTH-1:0] ctx_q      [NUM_REQ];

   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  grant_idx;
   logic             rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             slot_free, arb_en, grant_fire;
   logic [WIDTH-1:0] sum;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_req_data[gi] = req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Grants are withheld during reset and clear so no op can be lost to them.
   accum_sched_rr_arbiter #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_rr_arbiter (
      .valid_i  (req_valid),
      .ptr_i    (ptr_q),
      .enable_i (arb_en),
      .grant_o  (req_ready),
      .idx_o    (grant_idx)
   );

   always_comb begin
      slot_free   = !rsp_valid_q || rsp_ready;
      arb_en      = slot_free && !clear && !rst;
      grant_fire  = |req_ready;
      sum         = ctx_q[grant_idx] + w_req_data[grant_idx] + WIDTH'(1);
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      ptr_d       = ptr_q;
      if (grant_fire) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = grant_idx;
         rsp_data_d  = sum;
         ptr_d       = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            ctx_q[i] <= '0;
         end
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         ptr_q       <= '0;
      end else begin
         if (clear) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               ctx_q[i] <= '0;
            end
         end else if (grant_fire) begin
            ctx_q[grant_idx] <= sum;
         end
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         ptr_q       <= ptr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_accum_sched : directed and randomized checks against a behavioural model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_accum_sched;
   import accum_sched_pkg::*;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst, clear, rsp_ready;
   logic [N-1:0]   req_valid, req_ready;
   logic [N*W-1:0] req_data;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_data;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] m_ctx [N];
   int           m_ptr;
   logic         m_rv;
   int           m_id;
   logic [W-1:0] m_data;
   rsp_t         snap;

   accum_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_d(input int i, input logic [W-1:0] v);
      req_data[i*W +: W] = v;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_ctx[i] = '0;
      m_ptr  = 0;
      m_rv   = 1'b0;
      m_id   = 0;
      m_data = '0;
   endtask

   // First valid requester at or after the pointer, wrapping; -1 if none may go.
   function automatic int model_grant();
      if (rst || clear || !(!m_rv || rsp_ready)) return -1;
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   // Called just after a falling edge with inputs set; returns at the next one.
   task automatic tick();
      int           g;
      logic [N-1:0] e;
      logic [W-1:0] op;
      #1;
      g = model_grant();
      e = '0;
      if (g >= 0) e[g] = 1'b1;
      chk("req_ready", {60'd0, req_ready}, {60'd0, e});
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_rv});
      chk("rsp_id", {62'd0, rsp_id}, 64'(m_id));
      chk("rsp_data", {32'd0, rsp_data}, {32'd0, m_data});
      if (rst) begin
         model_reset();
      end else begin
         if (clear) begin
            for (int i = 0; i < N; i++) m_ctx[i] = '0;
         end
         if (g >= 0) begin
            op       = req_data[g*W +: W];
            m_ctx[g] = m_ctx[g] + op + 32'd1;
            m_rv     = 1'b1;
            m_id     = g;
            m_data   = m_ctx[g];
            m_ptr    = (g + 1) % N;
         end else if (rsp_ready) begin
            m_rv = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      clear     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      model_reset();
      chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("reset_rsp_id", {62'd0, rsp_id}, 64'd0);
      chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
      chk("reset_req_ready", {60'd0, req_ready}, 64'd0);
      tick();
      rst = 1'b0;

      // single requester
      req_valid = 4'b0001;
      set_d(0, 32'd5);
      tick();
      chk("single1_valid", {63'd0, rsp_valid}, 64'd1);
      chk("single1_id", {62'd0, rsp_id}, 64'd0);
      chk("single1_data", {32'd0, rsp_data}, 64'd6);
      tick();
      chk("single2_data", {32'd0, rsp_data}, 64'd12);

      // fairness over two laps
      rst = 1'b1; req_valid = '0; tick();
      rst = 1'b0; req_valid = 4'hF; req_data = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("fair_id", {62'd0, rsp_id}, 64'(i % 4));
         chk("fair_data", {32'd0, rsp_data}, (i < 4) ? 64'd1 : 64'd2);
      end

      // back-pressure with all requesters waiting
      snap.id = rsp_id; snap.data = rsp_data;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_req_ready", {60'd0, req_ready}, 64'd0);
         chk("bp_id_hold", {62'd0, rsp_id}, 64'd3);
         chk("bp_data_hold", {32'd0, rsp_data}, {32'd0, snap.data});
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_resume_id", {62'd0, rsp_id}, 64'd0);
      chk("bp_resume_data", {32'd0, rsp_data}, 64'd3);

      // wrap-around of one context
      rst = 1'b1; req_valid = '0; tick();
      rst = 1'b0; req_valid = 4'b0100; set_d(2, 32'hFFFF_FFFD);
      tick();
      chk("wrap_pre", {32'd0, rsp_data}, 64'hFFFF_FFFE);
      set_d(2, 32'd0);
      tick();
      chk("wrap_max", {32'd0, rsp_data}, 64'hFFFF_FFFF);
      tick();
      chk("wrap_zero", {32'd0, rsp_data}, 64'd0);

      // clear blocks the grant in its own cycle
      clear = 1'b1; req_valid = 4'b0010; set_d(1, 32'd3);
      #1;
      chk("clear_req_ready", {60'd0, req_ready}, 64'd0);
      tick();
      clear = 1'b0;
      tick();
      chk("clear_after_id", {62'd0, rsp_id}, 64'd1);
      chk("clear_after_data", {32'd0, rsp_data}, 64'd4);

      // reset while a response is stalled
      req_valid = '0; rsp_ready = 1'b0;
      tick();
      chk("rmf_pending", {63'd0, rsp_valid}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rmf_valid", {63'd0, rsp_valid}, 64'd0);
      req_valid = 4'b1100; set_d(2, 32'd7); set_d(3, 32'd9); rsp_ready = 1'b1;
      #1;
      chk("rmf_grant", {60'd0, req_ready}, 64'b0100);
      tick();
      chk("rmf_id", {62'd0, rsp_id}, 64'd2);
      chk("rmf_data", {32'd0, rsp_data}, 64'd8);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 63) == 0);
         clear     = ($urandom_range(0, 15) == 0);
         req_valid = N'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0:       set_d(i, W'($urandom_range(0, 7)));
               1:       set_d(i, 32'hFFFF_FFFF);
               default: set_d(i, W'($urandom));
            endcase
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/accum_sched.md
Name: accum_sched

Overview:
- Round-robin scheduler that time-shares one accumulate datapath (next = acc + operand + 1) between NUM_REQ requesters.
- Holds one private accumulator context per requester and grants at most one operation per cycle.
- Returns each updated value through a single-entry response register with valid/ready back-pressure.
- Sits between multiple client blocks and the shared accumulate function; it is the multi-tenant version of the single-stream accumulator.

Parameters:
- NUM_REQ, 4, number of requesters/contexts (>=2).
- WIDTH, 32, operand and accumulator width.
- ID_W, $clog2(NUM_REQ), width of the requester index (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous pulse; zeroes all contexts.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_data  input  NUM_REQ*WIDTH  operands, flattened; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot grant; a handshake completes when req_valid[i] && req_ready[i].
- rsp_valid  output  1  response register holds a result.
- rsp_id  output  ID_W  index of the requester the result belongs to.
- rsp_data  output  WIDTH  updated accumulator value of that context.
- rsp_ready  input  1  downstream accepts the response.

Behaviour:
- Reset (rst high at a clk edge):
  - all contexts, rsp_data and rsp_id = 0; rsp_valid = 0;
  - round-robin pointer = 0;
  - req_ready = 0 for that cycle.
  - rst has priority over every other input.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational, same cycle):
  - If slot_free && !clear, grant the first requester with req_valid set, searching from the pointer upward and wrapping modulo NUM_REQ.
  - req_ready is one-hot on the granted index, otherwise all zero.
  - req_ready never asserts for a requester whose req_valid is low.
- On an accepted handshake for requester g:
  - ctx[g] <= ctx[g] + req_data[g] + 1, truncated to WIDTH bits (wraps modulo 2^WIDTH; no saturation, no carry out).
  - rsp_data <= the new value; rsp_id <= g; rsp_valid <= 1.
  - pointer <= (g+1) mod NUM_REQ.
- Latency: the result is visible exactly 1 cycle after acceptance. Throughput is 1 op/cycle when rsp_ready is held high.
- Back-pressure:
  - rsp_valid && !rsp_ready: the response holds stable (rsp_id, rsp_data unchanged) and no grant is issued.
  - rsp_valid && rsp_ready with a new grant in the same cycle: the response is replaced (drain and fill together, no bubble).
  - rsp_valid && rsp_ready with no grant: rsp_valid <= 0.
- Pointer: moves only on a grant. An idle cycle leaves it unchanged.
- Back-to-back ops on the same context: the second op uses the first op's committed value (the context register updates at the accept edge). No hazard.
- clear:
  - all ctx <= 0; no grant that cycle;
  - the pointer is unchanged;
  - a pending response is unaffected and still obeys rsp_ready.
- rst mid-operation: a pending response is discarded (rsp_valid <= 0) and all state returns to reset values.
- req_data of non-granted requesters is ignored. Requesters must hold req_valid and req_data until granted (not checked).

Decomposition:
- Package accum_sched_pkg holds:
  - the default NUM_REQ and WIDTH localparams;
  - the response struct typedef rsp_t {id, data};
  - a function rr_pick(valid vector, pointer) returning the grant index and a found flag.
- One natural sub-module: rr_arbiter (parameter N; inputs valid, ptr, enable; outputs onehot grant and grant index).
- The context bank, datapath and response register stay in accum_sched.

Test Plan:
- Reset, single requester: NUM_REQ=4, rst then req_valid=0001 with req_data[0]=5, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=6. Second op with data 5 -> rsp_data=12.
- Fairness: all four req_valid held high, all data=0, rsp_ready=1 -> grants rotate in order 0,1,2,3,0. Every context reads 1 after the first lap and 2 after the second.
- Back-pressure: a response is pending, rsp_ready=0 for 3 cycles with all requesters valid -> req_ready=0000 and rsp_id/rsp_data stable. On rsp_ready=1, the grant resumes at the next pointer index with no lost or duplicated op.
- Wrap-around: ctx[2] preloaded via ops to 32'hFFFF_FFFE, then req_data[2]=0 -> rsp_data=32'hFFFF_FFFF. Next op with data 0 -> rsp_data=0.
- clear with simultaneous request: clear=1 and req_valid=0010 -> req_ready=0000 that cycle. The next cycle the grant goes to requester 1 with data 3 -> rsp_data=4.
- Reset mid-flight: rst asserted while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, all contexts 0, pointer 0. The first grant afterwards goes to the lowest valid index.
